// File: rtl/neuron_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac_seq
// Function : Sweeps a neuron's weight/activation BRAM pair, accumulates the
//            products, adds bias, optional ReLU, saturates to DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_mac_seq #(
  parameter int N_IN      = 28,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int RELU      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_EN,
  input  logic [DATA_W-1:0] W_DO,
  input  logic [DATA_W-1:0] X_DO,
  output logic [DATA_W-1:0] RESULT,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  localparam int c_last_issue = (N_IN > 1) ? (N_IN - 2) : 0;
  localparam logic signed [ACC_W-1:0] c_sat_max =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     r_state;
  state_t                     w_next;
  logic        [ADDR_W-1:0]   r_rd_addr;
  logic                       r_rd_en;
  logic        [DATA_W-1:0]   r_bias;
  logic signed [ACC_W-1:0]    r_acc;
  logic        [DATA_W-1:0]   r_result;
  logic                       r_busy;
  logic                       r_done;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_scaled;
  logic signed [ACC_W-1:0]    w_relu;
  logic        [DATA_W-1:0]   w_sat;
  logic                       w_last_issue;

  assign w_prod       = $signed(W_DO) * $signed(X_DO);
  assign w_prod_ext   = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  // Bias is aligned to the product's 2*FRAC_BITS fraction before the final shift.
  assign w_bias_ext   = {{(ACC_W-DATA_W-FRAC_BITS){r_bias[DATA_W-1]}}, r_bias, {FRAC_BITS{1'b0}}};
  assign w_sum        = r_acc + w_bias_ext;
  assign w_scaled     = w_sum >>> FRAC_BITS;
  assign w_relu       = ((RELU != 0) && w_scaled[ACC_W-1]) ? '0 : w_scaled;
  assign w_last_issue = (int'(r_rd_addr) == c_last_issue);

  always_comb begin
    w_sat = w_relu[DATA_W-1:0];
    if (w_relu > c_sat_max) begin
      w_sat = c_sat_max[DATA_W-1:0];
    end else if (w_relu < c_sat_min) begin
      w_sat = c_sat_min[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = (N_IN == 1) ? S_DRAIN : S_RUN;
      S_RUN:   if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: w_next = S_FINAL;
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Each RUN/DRAIN edge consumes the data for the address issued one edge earlier.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_bias    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_bias    <= BIAS;
            r_acc     <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc     <= r_acc + w_prod_ext;
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
        S_DRAIN: begin
          r_acc     <= r_acc + w_prod_ext;
          r_rd_en   <= 1'b0;
          r_rd_addr <= '0;
        end
        S_FINAL: begin
          r_result <= w_sat;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign RD_ADDR = r_rd_addr;
  assign RD_EN   = r_rd_en;
  assign RESULT  = r_result;
  assign BUSY    = r_busy;
  assign DONE    = r_done;

endmodule
`default_nettype wire
